// File: rtl/alu_cmd_sequencer.sv
// Request/response sequencer that drives a BreadBoard ALU from registers.
// Define ALU_SEQ_OPCOUNT_EN to add a saturating op_count output.
module alu_cmd_sequencer #(
  parameter int DATA_W     = 16,
  parameter int RES_W      = 32,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_use_acc,
  output logic [DATA_W-1:0] alu_inputA,
  output logic [DATA_W-1:0] alu_inputB,
  output logic [3:0]        alu_command,
  input  logic [RES_W-1:0]  alu_result,
  input  logic [1:0]        alu_error,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_result,
  output logic [1:0]        out_error,
  output logic [RES_W-1:0]  acc,
  output logic [1:0]        sticky_err,
  input  logic              clr_err,
  output logic              busy
`ifdef ALU_SEQ_OPCOUNT_EN
  ,
  output logic [15:0]       op_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    HOLD
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYC - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [3:0]        op_q, op_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              vld_q, vld_d;
  logic [RES_W-1:0]  res_q, res_d;
  logic [1:0]        err_q, err_d;
  logic [RES_W-1:0]  acc_q, acc_d;
  logic [1:0]        stk_q, stk_d;

  logic              in_is_op;
  logic              is_as;
  logic              is_mdv;
  logic              is_dv;
  logic              capture;
  logic [RES_W-1:0]  res_c;
  logic [1:0]        err_c;

  assign in_is_op = (in_op >= 4'd1) && (in_op <= 4'd5);
  assign is_as    = (op_q == 4'd1) || (op_q == 4'd2);
  assign is_dv    = (op_q == 4'd4) || (op_q == 4'd5);
  assign is_mdv   = (op_q == 4'd3) || is_dv;
  assign capture  = (state_q == DRIVE) && (cnt_q == 4'd0);

  // add/sub keep only the operand-width part; errors apply per opcode class
  always_comb begin
    res_c = '0;
    unique case (1'b1)
      is_as:   res_c = RES_W'(alu_result[DATA_W-1:0]);
      is_mdv:  res_c = alu_result;
      default: res_c = '0;
    endcase
    err_c = {is_dv & alu_error[1], is_as & alu_error[0]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cmd_d   = cmd_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    res_d   = res_q;
    err_d   = err_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_use_acc ? acc_q[DATA_W-1:0] : in_a;
          b_d     = in_b;
          cmd_d   = in_is_op ? in_op : 4'd0;
          op_d    = in_is_op ? in_op : 4'd0;
          cnt_d   = CNT_INIT;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == 4'd0) begin
          cmd_d   = 4'd0;
          vld_d   = 1'b1;
          res_d   = res_c;
          err_d   = err_c;
          state_d = HOLD;
          if ((op_q != 4'd0) && !err_c[1]) acc_d = res_c;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // a clear in the capture cycle still keeps the freshly captured error
    stk_d = (clr_err ? 2'b00 : stk_q) | (capture ? err_c : 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cmd_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      res_q   <= '0;
      err_q   <= '0;
      acc_q   <= '0;
      stk_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cmd_q   <= cmd_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
      stk_q   <= stk_d;
    end
  end

`ifdef ALU_SEQ_OPCOUNT_EN
  logic [15:0] opc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      opc_q <= '0;
    end else if ((state_q == HOLD) && out_ready &&
                 (op_q != 4'd0) && (opc_q != 16'hFFFF)) begin
      opc_q <= opc_q + 16'd1;
    end
  end

  assign op_count = opc_q;
`endif

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign alu_inputA  = a_q;
  assign alu_inputB  = b_q;
  assign alu_command = cmd_q;
  assign out_valid   = vld_q;
  assign out_result  = res_q;
  assign out_error   = err_q;
  assign acc         = acc_q;
  assign sticky_err  = stk_q;

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator side of the BreadBoard ALU interface. Accepts operation requests over a valid/ready handshake and drives the ALU's inputA, inputB and command lines from registers.
- Waits a programmable settle time, then captures result/error, masks error bits that do not apply to the opcode, and presents the response over a second valid/ready handshake.
- Keeps a 32-bit accumulator so operations can chain, and a sticky error register.

Parameters:
- DATA_W, 16, operand width driven to the ALU
- RES_W, 32, ALU result width
- SETTLE_CYC, 1, cycles the ALU inputs are held stable before capture (1..15)

Ports:
- clk  input  1  clock; all logic on the rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid&in_ready at an edge
- in_op  input  4  0 nop, 1 add, 2 sub, 3 mul, 4 div, 5 mod, 6-15 reserved
- in_a  input  DATA_W  operand A
- in_b  input  DATA_W  operand B
- in_use_acc  input  1  1: operand A = acc[DATA_W-1:0] instead of in_a
- alu_inputA  output  DATA_W  registered drive to ALU inputA
- alu_inputB  output  DATA_W  registered drive to ALU inputB
- alu_command  output  4  registered drive to ALU command
- alu_result  input  RES_W  ALU result
- alu_error  input  2  ALU error: [1] divide-by-zero, [0] overflow
- out_valid  output  1  response valid
- out_ready  input  1  response consumed when out_valid&out_ready at an edge
- out_result  output  RES_W  captured, width-corrected result
- out_error  output  2  masked error for this op
- acc  output  RES_W  accumulator
- sticky_err  output  2  OR of all masked errors since reset/clear
- clr_err  input  1  clears sticky_err
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst high at an edge) forces state IDLE, regardless of current state (including mid-DRIVE or HOLD). Zeroes outputs and registers:
  - in_ready=1 after reset, out_valid=0, out_result=0, out_error=0
  - acc=0, sticky_err=0
  - alu_inputA=0, alu_inputB=0, alu_command=0
  - settle counter=0
  - An in-flight op is discarded with no response.
- FSM states: IDLE, DRIVE, HOLD. in_ready=1 only in IDLE.
- IDLE, on accept:
  - Register operand A (in_use_acc ? acc[15:0] : in_a) into alu_inputA and in_b into alu_inputB.
  - Register alu_command = in_op for ops 1-5; 0 for nop and reserved ops.
  - Load counter=SETTLE_CYC-1; go to DRIVE.
- DRIVE:
  - Counter decrements each cycle.
  - On the edge where counter==0, capture into out_result/out_error, set out_valid=1, go to HOLD.
  - out_valid therefore rises SETTLE_CYC edges after the accepting edge.
- Width rule:
  - ops 1/2: out_result = {16'b0, alu_result[15:0]}
  - ops 3/4/5: full alu_result
  - nop/reserved: 0
- Error mask:
  - out_error[0] = alu_error[0] only for ops 1/2
  - out_error[1] = alu_error[1] only for ops 4/5
  - All other combinations read 0.
- Accumulator: acc <= captured out_result on the capture edge for ops 1-5. Unchanged for nop/reserved and on errored div/mod.
- sticky_err:
  - On the capture edge, sticky_err |= masked error.
  - clr_err clears it; a simultaneous clr_err and new error leaves the new error bits set.
- HOLD:
  - alu_command returns to 0 on the capture edge; operands hold their values.
  - out_result/out_error stay stable while out_ready=0.
  - On out_valid&out_ready: out_valid=0, go to IDLE. Next accept is possible the following edge.
  - No pipelining: one op in flight.
- in_* inputs are ignored outside IDLE.

Optional Feature:
- Macro ALU_SEQ_OPCOUNT_EN.
- When defined: extra output op_count (16 bits), reset 0, increments on each response handshake for ops 1-5, saturates at 0xFFFF.
- When undefined: op_count is absent and no counter logic is built. All other behaviour is identical.

Test Plan:
- in_a=249, in_b=69, ops 1..5 in sequence, out_ready=1 -> out_result 318, 180, 17181, 3, 42; out_error 00 each; out_valid SETTLE_CYC edges after accept.
- After mul 249*69 (acc=17181): in_use_acc=1, in_b=1, op 1 -> out_result 17182, acc=17182.
- in_a=0x7D00, in_b=0x3E81, op 1 -> out_result 48001, out_error 01, sticky_err 01. Then the same operands with op 3 -> out_error 00.
- in_a=10, in_b=0: op 4 -> out_error 10, acc unchanged, sticky_err 10. op 1 -> out_result 10, out_error 00 (dbz masked).
- out_ready held 0 for 5 cycles in HOLD -> out_valid, out_result and out_error stable; in_ready 0; a new in_valid is ignored. out_ready=1 -> IDLE next edge.
- rst asserted while in DRIVE (SETTLE_CYC=3) -> next edge: IDLE, out_valid 0, alu_command 0, acc 0, no response produced; clr_err pulse with a simultaneous dbz capture -> sticky_err 10.
